// File: rtl/data_sync_tx.sv
// rtl/data_sync_tx.sv - source-side launcher for a bus-plus-enable CDC synchronizer
module data_sync_tx #(
  parameter int BUS_WIDTH   = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [BUS_WIDTH-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [BUS_WIDTH-1:0]          unsync_bus,
  output logic                          bus_enable,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   COUNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   COUNT_MAX = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ASSERT = 2'd2;
  localparam logic [1:0] ST_GAP    = 2'd3;

  logic [BUS_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]       count_q, count_d;
  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0] bus_q, bus_d;
  logic                 en_q, en_d;
  logic                 done_q, done_d;
  logic                 push, pop, fifo_empty;

  assign in_ready   = (count_q != COUNT_MAX);
  assign fifo_empty = (count_q == '0);
  assign push       = in_valid & in_ready;

  // The bus only ever loads on the edge entering SETUP, so it is settled before the enable rises.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bus_d   = bus_q;
    en_d    = en_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          bus_d   = mem_q[rd_ptr_q];
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        en_d    = 1'b1;
        cnt_d   = HOLD_LOAD;
        state_d = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (cnt_q == '0) begin
          en_d    = 1'b0;
          cnt_d   = GAP_LOAD;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        if (cnt_q == '0) begin
          done_d = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            bus_d   = mem_q[rd_ptr_q];
            state_d = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bus_q    <= '0;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bus_q    <= bus_d;
      en_q     <= en_d;
      done_q   <= done_d;
    end
  end

  assign unsync_bus = bus_q;
  assign bus_enable = en_q;
  assign busy       = (state_q != ST_IDLE);
  assign tx_done    = done_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_data_sync_tx.sv
// tb/tb_data_sync_tx.sv - scoreboard bench for data_sync_tx with an inline receiver model
module tb_data_sync_tx;

  localparam int HOLD   = 4;
  localparam int GAP    = 4;
  localparam int DEPTH  = 4;
  localparam int PERIOD = 1 + HOLD + GAP;

  logic       CLK, RST;
  logic [7:0] in_data;
  logic       in_valid, in_ready;
  logic [7:0] unsync_bus;
  logic       bus_enable, busy, tx_done;
  logic [2:0] fifo_count;

  data_sync_tx #(.BUS_WIDTH(8), .FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .unsync_bus(unsync_bus), .bus_enable(bus_enable), .busy(busy), .tx_done(tx_done),
    .fifo_count(fifo_count)
  );

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  logic [7:0] sb[$];
  logic [7:0] rx_exp[$];

  always @(posedge CLK) begin
    if (RST && in_valid && in_ready) sb.push_back(in_data);
  end

  logic       rx_s1, rx_s2, rx_s3, rx_pulse;
  logic [7:0] rx_bus;
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_s1 <= 0; rx_s2 <= 0; rx_s3 <= 0; rx_pulse <= 0; rx_bus <= '0;
    end else begin
      rx_s1    <= bus_enable;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      rx_pulse <= rx_s2 & ~rx_s3;
      if (rx_s2 & ~rx_s3) rx_bus <= unsync_bus;
    end
  end

  int         cyc = 0, hi_cnt = 0, gap_cnt = 0, rises = 0, last_rise = -1, rx_pulses = 0;
  logic       prev_en = 0, win = 0, in_gap = 0;
  logic [7:0] prev_bus = '0;
  bit         chk_period = 0, rx_on = 0, seen99 = 0;

  always @(negedge CLK) begin
    cyc++;
    if (!RST) begin
      prev_en = 0; win = 0; in_gap = 0; hi_cnt = 0; gap_cnt = 0;
    end else begin
      if (unsync_bus == 8'h99) seen99 = 1;
      if (win && !tx_done) check_eq("bus_stable", unsync_bus, prev_bus);
      if (bus_enable && !prev_en) begin
        rises++;
        check_eq("sb_has_word", sb.size() > 0, 1);
        if (sb.size() > 0) check_eq("sb_word", unsync_bus, sb.pop_front());
        if (chk_period && last_rise >= 0) check_eq("word_period", cyc - last_rise, PERIOD);
        last_rise = cyc;
        hi_cnt = 0;
      end
      if (bus_enable) hi_cnt++;
      if (!bus_enable && prev_en) begin
        check_eq("hold_len", hi_cnt, HOLD);
        in_gap = 1;
        gap_cnt = 0;
      end
      if (in_gap) begin
        if (tx_done) begin
          check_eq("gap_len", gap_cnt, GAP);
          in_gap = 0;
        end else gap_cnt++;
      end
      if (rx_on && rx_pulse) begin
        rx_pulses++;
        check_eq("rx_has_word", rx_exp.size() > 0, 1);
        if (rx_exp.size() > 0) check_eq("rx_word", rx_bus, rx_exp.pop_front());
      end
      if (bus_enable) win = 1;
      if (tx_done) win = 0;
      prev_en  = bus_enable;
      prev_bus = unsync_bus;
    end
  end

  int full_seen = 0;

  task automatic push_word(input logic [7:0] d);
    int n;
    n = 0;
    @(negedge CLK);
    in_data  = d;
    in_valid = 1;
    while (!in_ready && n < 200) begin
      full_seen++;
      check_eq("ready_low_cnt", fifo_count, DEPTH);
      @(negedge CLK);
      n++;
    end
    check_eq("push_timeout", n < 200, 1);
    @(posedge CLK);
  endtask

  task automatic wait_en();
    int n;
    n = 0;
    while (!bus_enable && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check_eq("wait_en_timeout", n < 100, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || fifo_count != 0) && n < 500) begin
      @(negedge CLK);
      n++;
    end
    check_eq("drain_timeout", n < 500, 1);
    check_eq("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  int rises_before;

  initial begin
    RST = 0; in_valid = 1; in_data = 8'($urandom);
    repeat (3) begin
      @(negedge CLK);
      in_data = 8'($urandom);
    end
    @(negedge CLK);
    check_eq("rst_bus", unsync_bus, 0);
    check_eq("rst_en", bus_enable, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", tx_done, 0);
    check_eq("rst_cnt", fifo_count, 0);
    check_eq("rst_ready", in_ready, 1);
    #2 RST = 1;
    #1 check_eq("rel_cnt", fifo_count, 0);
    in_valid = 0;
    @(negedge CLK);
    check_eq("rel_cnt_edge", fifo_count, 0);
    check_eq("rel_busy", busy, 0);

    // single word, cycle-accurate
    @(negedge CLK);
    in_data = 8'hA5; in_valid = 1;
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 0;
    check_eq("sw_cnt", fifo_count, 1);
    for (int e = 1; e <= 11; e++) begin
      @(negedge CLK);
      check_eq("sw_bus", unsync_bus, 8'hA5);
      check_eq("sw_en", bus_enable, (e >= 2 && e <= 5));
      check_eq("sw_done", tx_done, (e == 10));
      check_eq("sw_busy", busy, (e >= 1 && e <= 9));
    end
    wait_idle();

    // burst with continuous valid
    chk_period = 1; last_rise = -1; rises = 0; full_seen = 0;
    for (int i = 1; i <= 6; i++) push_word(8'(i));
    @(negedge CLK);
    in_valid = 0;
    wait_idle();
    chk_period = 0;
    check_eq("burst_rises", rises, 6);
    check_eq("burst_full_seen", full_seen > 0, 1);

    // receiver model
    rx_on = 1; rx_pulses = 0;
    rx_exp.push_back(8'h3C); rx_exp.push_back(8'hC3); rx_exp.push_back(8'hFF);
    push_word(8'h3C); push_word(8'hC3); push_word(8'hFF);
    @(negedge CLK);
    in_valid = 0;
    wait_idle();
    repeat (6) @(negedge CLK);
    check_eq("rx_pulses", rx_pulses, 3);
    check_eq("rx_exp_left", rx_exp.size(), 0);
    rx_on = 0;

    // full FIFO rejects an extra word
    seen99 = 0;
    push_word(8'h11);
    @(negedge CLK);
    in_valid = 0;
    wait_en();
    for (int i = 0; i < 4; i++) push_word(8'(8'h21 + i));
    @(negedge CLK);
    in_data = 8'h99; in_valid = 1;
    check_eq("full_ready", in_ready, 0);
    check_eq("full_cnt", fifo_count, DEPTH);
    repeat (2) begin
      @(negedge CLK);
      check_eq("full_cnt_hold", fifo_count, DEPTH);
    end
    in_valid = 0;
    wait_idle();
    check_eq("no_99", seen99, 0);

    // reset in the middle of ASSERT with two words queued
    push_word(8'h41);
    @(negedge CLK);
    in_valid = 0;
    wait_en();
    push_word(8'h42); push_word(8'h43);
    @(negedge CLK);
    in_valid = 0;
    check_eq("mid_en_before", bus_enable, 1);
    check_eq("mid_cnt_before", fifo_count, 2);
    #3 RST = 0;
    #1;
    check_eq("mid_en", bus_enable, 0);
    check_eq("mid_bus", unsync_bus, 0);
    check_eq("mid_cnt", fifo_count, 0);
    check_eq("mid_busy", busy, 0);
    check_eq("mid_ready", in_ready, 1);
    sb.delete();
    repeat (2) @(negedge CLK);
    #3 RST = 1;
    rises_before = rises;
    repeat (30) @(negedge CLK);
    check_eq("post_busy", busy, 0);
    check_eq("post_cnt", fifo_count, 0);
    check_eq("post_no_rise", rises, rises_before);
    check_eq("post_bus", unsync_bus, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
